mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Controller for the M-extension execution resources in the EXC stage. It accepts one multiply/divide request from the EXA stage and sequences the shared multi-cycle multiplier through its start/ready handshake. It also runs an internal iterative divider, handles the RISC-V divide corner cases, and raises a stall to the pipeline until a single-cycle result pulse is produced.

## Interface
- XLEN, 64, operand/result width
- DIV_LAT_FULL, 64, divider iterations for 64-bit ops (fixed 1 bit/cycle)
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  M-op present in EXA; op/operands held stable while stall_req=1
- req_op  in  4  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8–15 reserved
- req_word  in  1  RV64 W variant (legal with ops 0, 4–7 only)
- req_a, req_b  in  64  rs1/rs2 values
- flush  in  1  kill in-flight op
- stall_req  out  1  hold EXA and earlier stages
- busy  out  1  state≠IDLE
- rsp_valid  out  1  one-cycle result pulse
- rsp_result  out  64  result, valid only with rsp_valid
- mul_start  out  1  held high until mul_ready; deassertion aborts the multiplier
- mul_a, mul_b  out  64  multiplier operands
- mul_signed_a, mul_signed_b  out  1  operand signedness
- mul_ready  in  1  multiplier done
- mul_result  in  128  full product

## Operation
- States: IDLE, MUL_WAIT, DIV_RUN, DONE.
- Reset: state IDLE. All outputs 0, including registered operands and result.
- IDLE with req_valid=1, legal op, flush=0: latch op and operands.
  - MUL ops → MUL_WAIT.
  - DIV ops with special case → DONE.
  - Other DIV ops → DIV_RUN.
- Illegal op (reserved op, or req_word with ops 1–3): ignored. No stall, no rsp_valid.
- Signedness:
  - MUL/MULH: signed_a=signed_b=1.
  - MULHSU: signed_a=1, signed_b=0.
  - MULHU: signed_a=signed_b=0.
- MUL result selection:
  - MUL → product[63:0].
  - MULH/MULHSU/MULHU → product[127:64].
  - MULW → sign-extended product[31:0].
- MUL_WAIT: mul_start=1. On mul_ready, capture the selected result and go to DONE.
- Divider operand preparation:
  - Signed ops use magnitudes; the divider runs unsigned.
  - W ops use the low 32 bits, sign- or zero-extended per op, and run 32 iterations (otherwise DIV_LAT_FULL).
- Divider result sign fixup:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - W results are sign-extended from bit 31, including DIVUW/REMUW.
- Divide special cases (resolved in IDLE, no iteration):
  - b==0: quotient all ones (W: all ones after sign extension); remainder = a (W: sext(a[31:0])).
  - Signed overflow (a = most negative value, b = −1, at the op width): quotient = a; remainder 0.
- DIV_RUN: one restoring step per cycle. After the last step → DONE.
- DONE: rsp_valid=1, rsp_result driven from the result register, stall_req=0. Next state IDLE.
- stall_req = req_valid & legal & flush=0 & (state≠DONE).
  - Combinational, so it is high in the accepting cycle itself.
- flush in any state: next state IDLE, mul_start drops, partial divider state discarded, no rsp_valid.
  - flush in DONE suppresses that cycle's rsp_valid.

## Timing
- Request accepted at cycle T. MUL_WAIT and DIV_RUN begin at T+1.
- MUL: mul_ready at T+k → rsp_valid at T+k+1. stall_req high for T..T+k.
- DIV/REM: rsp_valid at T+65, or T+33 for W ops.
- Special-case divide: rsp_valid at T+1; one stall cycle.
- The pipeline advances in the DONE cycle. A back-to-back request is accepted in the following IDLE cycle, so at most one rsp_valid per two cycles.
- mul_ready outside MUL_WAIT is ignored.
- Simultaneous flush and mul_ready: flush wins.
- Reset asserted mid-operation: immediate IDLE, outputs 0.

## Structure
- Package mdu_pkg holds:
  - mdu_op_e (4-bit op encoding)
  - mdu_state_e
  - XLEN constant
  - Divide special-case result constants
- Sub-module mdu_div_iter (unsigned restoring divider):
  - Inputs: start, width-select (32/64), dividend, divisor, abort.
  - Outputs: done, quotient, remainder.
- Sign fixup and W extension stay in mdu_sequencer.

## Test plan
- MUL 3×(−5), mock multiplier ready after 4 cycles → mul_signed_a=signed_b=1, stall 5 cycles, rsp_result 0xFFFF_FFFF_FFFF_FFF1.
- DIV −7/2 → 0xFFFF_FFFF_FFFF_FFFD at T+65. REM −7/2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIVU 5/0 → 0xFFFF_FFFF_FFFF_FFFF. REMU 5/0 → 5. Each with rsp_valid at T+1.
- DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000. REM same operands → 0.
- DIVUW a=0x1_FFFF_FFFF, b=1 → 0xFFFF_FFFF_FFFF_FFFF at T+33. MULW 0x7FFF_FFFF×2 → 0xFFFF_FFFF_FFFF_FFFE.
- flush at cycle 10 of DIV → IDLE next cycle, stall_req 0, no rsp_valid. Reset low during MUL_WAIT → mul_start 0 and all outputs 0 immediately.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the M-extension sequencer
package mdu_pkg;

  // Fixed at 64: the W-op handling hardwires the 32/64-bit split.
  localparam int XLEN = 64;

  typedef enum logic [3:0] {
    OP_MUL    = 4'd0,
    OP_MULH   = 4'd1,
    OP_MULHSU = 4'd2,
    OP_MULHU  = 4'd3,
    OP_DIV    = 4'd4,
    OP_DIVU   = 4'd5,
    OP_REM    = 4'd6,
    OP_REMU   = 4'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_WAIT,
    ST_DIV_RUN,
    ST_DONE
  } mdu_state_e;

  localparam logic [XLEN-1:0] DIV0_QUOT     = '1;
  localparam logic [XLEN-1:0] OVF_REM       = '0;
  localparam logic [XLEN-1:0] INT_MIN64     = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] INT_MIN32_EXT = {{(XLEN-31){1'b1}}, 31'd0};

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// rtl/mdu_div_iter.sv - unsigned restoring divider, one quotient bit per cycle
module mdu_div_iter
  import mdu_pkg::*;
#(
  parameter int LAT_FULL = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            abort,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] div_q;
  logic [6:0]      cnt_q;
  logic [XLEN:0]   partial;
  logic            fits;

  // Outputs are the post-step values so the caller can capture on done.
  always_comb begin
    partial   = {rem_q, quo_q[XLEN-1]};
    fits      = (partial >= {1'b0, div_q});
    remainder = fits ? (partial[XLEN-1:0] - div_q) : partial[XLEN-1:0];
    quotient  = {quo_q[XLEN-2:0], fits};
    done      = (cnt_q == 7'd1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else if (abort) begin
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      // W ops left-align the 32-bit dividend so the same MSB-first step applies.
      quo_q <= word ? {dividend[31:0], 32'd0} : dividend;
      div_q <= divisor;
      cnt_q <= word ? 7'd32 : 7'(LAT_FULL);
    end else if (cnt_q != 7'd0) begin
      rem_q <= remainder;
      quo_q <= quotient;
      cnt_q <= cnt_q - 7'd1;
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - EXC-stage multiply/divide sequencer with stall and result pulse
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int DIV_LAT_FULL = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [3:0]        req_op,
  input  logic              req_word,
  input  logic [XLEN-1:0]   req_a,
  input  logic [XLEN-1:0]   req_b,
  input  logic              flush,
  output logic              stall_req,
  output logic              busy,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_result,
  output logic              mul_start,
  output logic [XLEN-1:0]   mul_a,
  output logic [XLEN-1:0]   mul_b,
  output logic              mul_signed_a,
  output logic              mul_signed_b,
  input  logic              mul_ready,
  input  logic [2*XLEN-1:0] mul_result
);

  mdu_state_e      state_q, state_d;
  logic [3:0]      op_q;
  logic            word_q, neg_quo_q, neg_rem_q;
  logic [XLEN-1:0] res_q;

  logic            legal, accept, is_mul, div_signed, is_rem;
  logic            a_neg, b_neg, div_zero, div_ovf, special;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_w, special_res;
  logic            div_done;
  logic [XLEN-1:0] div_quo, div_rem, quo_fix, rem_fix, div_raw, div_sel, mul_sel;

  always_comb begin
    legal      = !req_op[3] && !(req_word && req_op[2] == 1'b0 && req_op[1:0] != 2'b00);
    is_mul     = !req_op[2];
    div_signed = !req_op[0];
    is_rem     = req_op[1];
    a_ext      = req_word ? (div_signed ? sext32(req_a[31:0]) : {32'd0, req_a[31:0]}) : req_a;
    b_ext      = req_word ? (div_signed ? sext32(req_b[31:0]) : {32'd0, req_b[31:0]}) : req_b;
    a_w        = req_word ? sext32(req_a[31:0]) : req_a;
    a_neg      = div_signed && a_ext[XLEN-1];
    b_neg      = div_signed && b_ext[XLEN-1];
    a_mag      = a_neg ? -a_ext : a_ext;
    b_mag      = b_neg ? -b_ext : b_ext;
    div_zero   = (b_ext == '0);
    div_ovf    = div_signed && (b_ext == '1) &&
                 (a_ext == (req_word ? INT_MIN32_EXT : INT_MIN64));
    special    = div_zero || div_ovf;
    if (div_zero) special_res = is_rem ? a_w : DIV0_QUOT;
    else          special_res = is_rem ? OVF_REM : a_w;
    accept     = (state_q == ST_IDLE) && req_valid && legal && !flush;
  end

  mdu_div_iter #(.LAT_FULL(DIV_LAT_FULL)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && !is_mul && !special),
    .word      (req_word),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .abort     (flush),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    quo_fix = neg_quo_q ? -div_quo : div_quo;
    rem_fix = neg_rem_q ? -div_rem : div_rem;
    div_raw = op_q[1] ? rem_fix : quo_fix;
    div_sel = word_q ? sext32(div_raw[31:0]) : div_raw;
    if (op_q[1:0] == 2'b00) mul_sel = word_q ? sext32(mul_result[31:0]) : mul_result[XLEN-1:0];
    else                    mul_sel = mul_result[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) state_d = is_mul ? ST_MUL_WAIT : (special ? ST_DONE : ST_DIV_RUN);
      ST_MUL_WAIT: begin
        mul_start = 1'b1;
        if (mul_ready) state_d = ST_DONE;
      end
      ST_DIV_RUN: if (div_done) state_d = ST_DONE;
      ST_DONE: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d   = ST_IDLE;
      mul_start = 1'b0;
      rsp_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q         <= '0;
      word_q       <= 1'b0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      res_q        <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      mul_signed_a <= 1'b0;
      mul_signed_b <= 1'b0;
    end else begin
      if (accept) begin
        op_q      <= req_op;
        word_q    <= req_word;
        neg_quo_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        if (is_mul) begin
          mul_a        <= req_a;
          mul_b        <= req_b;
          mul_signed_a <= (req_op[1:0] != 2'b11);
          mul_signed_b <= !req_op[1];
        end else if (special) begin
          res_q <= special_res;
        end
      end
      if (state_q == ST_MUL_WAIT && mul_ready && !flush) res_q <= mul_sel;
      if (state_q == ST_DIV_RUN && div_done && !flush)   res_q <= div_sel;
    end
  end

  // Gated by reset so every output reads 0 while reset is held.
  assign stall_req  = reset && req_valid && legal && !flush && (state_q != ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_result = rsp_valid ? res_q : '0;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - directed-vector bench for mdu_sequencer
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, req_valid, req_word, flush, mul_ready;
  logic [3:0]   req_op;
  logic [63:0]  req_a, req_b;
  logic [127:0] mul_result;
  logic         stall_req, busy, rsp_valid, mul_start, mul_signed_a, mul_signed_b;
  logic [63:0]  rsp_result, mul_a, mul_b;

  int n_checks = 0;
  int n_pass   = 0;

  mdu_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_word     (req_word),
    .req_a        (req_a),
    .req_b        (req_b),
    .flush        (flush),
    .stall_req    (stall_req),
    .busy         (busy),
    .rsp_valid    (rsp_valid),
    .rsp_result   (rsp_result),
    .mul_start    (mul_start),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_signed_a (mul_signed_a),
    .mul_signed_b (mul_signed_b),
    .mul_ready    (mul_ready),
    .mul_result   (mul_result)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and follows it to the result pulse; mock multiplier
  // raises mul_ready in the mul_lat-th cycle that mul_start is seen high.
  task automatic run_op(input string tag, input logic [3:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [127:0] prod, input int mul_lat, input logic stray,
                        input logic exp_sa, input logic exp_sb,
                        input logic [63:0] exp_res, input int exp_lat);
    int   n, stalls, starts;
    logic sa, sb;
    sa = 1'b0; sb = 1'b0; starts = 0; n = 0;
    req_valid = 1'b1; req_op = op; req_word = w; req_a = a; req_b = b;
    mul_result = prod; mul_ready = 1'b0;
    #1;
    stalls = stall_req ? 1 : 0;
    while (!rsp_valid && n < 200) begin
      step();
      n++;
      mul_ready = (op < 4) ? 1'b0 : stray;
      if (mul_start) begin
        starts++;
        sa = mul_signed_a;
        sb = mul_signed_b;
        if (starts == mul_lat) mul_ready = 1'b1;
      end
      #1;
      if (stall_req) stalls++;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " result"}, rsp_result, exp_res);
    check({tag, " stall cycles"}, stalls, exp_lat);
    if (op < 4) begin
      check({tag, " signed_a"}, sa, exp_sa);
      check({tag, " signed_b"}, sb, exp_sb);
      check({tag, " mul_a"}, mul_a, a);
    end
    step();
    req_valid = 1'b0;
    mul_ready = 1'b0;
    #1;
    check({tag, " idle after"}, {busy, rsp_valid}, 2'b00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    reset = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_word = 1'b0;
    req_a = '0; req_b = '0; flush = 1'b0; mul_ready = 1'b0; mul_result = '0;
    step(); step();
    check("reset outputs", {stall_req, busy, rsp_valid, mul_start, mul_signed_a, mul_signed_b},
          6'b0);
    check("reset data", {rsp_result, mul_a}, 128'd0);
    reset = 1'b1;
    step();
    check("idle after reset", {busy, rsp_valid, mul_start}, 3'b000);

    // Multiplies
    run_op("MUL 3x-5", OP_MUL, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB,
           {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1}, 4, 1'b0, 1'b1, 1'b1,
           64'hFFFF_FFFF_FFFF_FFF1, 5);
    run_op("MULW", OP_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2,
           128'h0000_0000_FFFF_FFFE, 3, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4);
    run_op("MULHU", OP_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
           {64'd1, 64'hFFFF_FFFF_FFFF_FFFE}, 1, 1'b0, 1'b0, 1'b0, 64'd1, 2);
    run_op("MULHSU", OP_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
           {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE}, 2, 1'b0, 1'b1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFF, 3);

    // Iterative divides (stray mul_ready must be ignored)
    run_op("DIV -7/2", OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '0, 0, 1'b1,
           1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("REM -7/2", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '0, 0, 1'b0,
           1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("DIV 100/7", OP_DIV, 1'b0, 64'd100, 64'd7, '0, 0, 1'b0, 1'b0, 1'b0, 64'd14, 65);
    run_op("REM 100/-7", OP_REM, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, '0, 0, 1'b0,
           1'b0, 1'b0, 64'd2, 65);
    run_op("DIVU max/16", OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, '0, 0, 1'b1,
           1'b0, 1'b0, 64'h0FFF_FFFF_FFFF_FFFF, 65);
    run_op("REMU max/16", OP_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, '0, 0, 1'b0,
           1'b0, 1'b0, 64'd15, 65);
    run_op("DIVUW", OP_DIVU, 1'b1, 64'h1_FFFF_FFFF, 64'd1, '0, 0, 1'b0,
           1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op("DIVW -7/2", OP_DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, '0, 0, 1'b0,
           1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_op("REMUW 16/3", OP_REMU, 1'b1, 64'hABCD_0000_0000_0010, 64'd3, '0, 0, 1'b0,
           1'b0, 1'b0, 64'd1, 33);

    // Special cases
    run_op("DIVU 5/0", OP_DIVU, 1'b0, 64'd5, 64'd0, '0, 0, 1'b0, 1'b0, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("REMU 5/0", OP_REMU, 1'b0, 64'd5, 64'd0, '0, 0, 1'b0, 1'b0, 1'b0, 64'd5, 1);
    run_op("DIV ovf", OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, '0, 0,
           1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1);
    run_op("REM ovf", OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, '0, 0,
           1'b0, 1'b0, 1'b0, 64'd0, 1);
    run_op("REMUW x/0", OP_REMU, 1'b1, 64'h1234_0000_8000_0005, 64'hFFFF_0000_0000_0000, '0,
           0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_8000_0005, 1);
    run_op("DIVW ovf", OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, '0, 0,
           1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_8000_0000, 1);

    // Illegal ops are ignored
    req_valid = 1'b1; req_op = 4'd8; req_word = 1'b0;
    #1;
    check("reserved op stall", stall_req, 1'b0);
    step(); step();
    check("reserved op idle", {busy, rsp_valid}, 2'b00);
    req_op = OP_MULH; req_word = 1'b1;
    #1;
    check("MULHW stall", stall_req, 1'b0);
    step(); step();
    check("MULHW idle", {busy, rsp_valid, mul_start}, 3'b000);
    req_valid = 1'b0; req_word = 1'b0;

    // Flush at cycle 10 of a long divide
    req_valid = 1'b1; req_op = OP_DIV; req_a = 64'd100; req_b = 64'd7;
    for (int i = 0; i < 10; i++) step();
    check("div busy before flush", busy, 1'b1);
    flush = 1'b1; req_valid = 1'b0;
    #1;
    check("flush cycle stall", stall_req, 1'b0);
    step();
    flush = 1'b0;
    #1;
    check("after flush", {busy, stall_req, rsp_valid}, 3'b000);
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (rsp_valid) pulses++;
    end
    check("no pulse after flush", pulses, 0);

    // Flush in DONE suppresses the pulse
    req_valid = 1'b1; req_op = OP_DIVU; req_a = 64'd5; req_b = 64'd0;
    step();
    flush = 1'b1;
    #1;
    check("flush in DONE", rsp_valid, 1'b0);
    step();
    flush = 1'b0; req_valid = 1'b0;
    #1;
    check("after DONE flush", {busy, rsp_valid}, 2'b00);

    // Flush beats a simultaneous mul_ready
    req_valid = 1'b1; req_op = OP_MUL; req_a = 64'd3; req_b = 64'd4; mul_result = 128'd12;
    step(); step();
    mul_ready = 1'b1; flush = 1'b1; req_valid = 1'b0;
    step();
    mul_ready = 1'b0; flush = 1'b0;
    #1;
    check("flush vs mul_ready", {busy, rsp_valid, mul_start}, 3'b000);

    // Reset during MUL_WAIT
    req_valid = 1'b1; req_op = OP_MUL; req_a = 64'd9; req_b = 64'd9;
    step(); step();
    check("mul_start before reset", mul_start, 1'b1);
    reset = 1'b0;
    #1;
    check("reset mid-op ctrl", {mul_start, busy, stall_req, rsp_valid, mul_signed_a, mul_signed_b},
          6'b0);
    check("reset mid-op data", {mul_a, rsp_result}, 128'd0);
    req_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("idle after reset release", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
